// File: rtl/dpe_pcap_arb_pkg.sv
// Shared types for the DPE PCAP capture arbiter.
// Beat fields are sized for the widest tap and trimmed at the ports.
package dpe_pcap_arb_pkg;

  localparam int MAX_PORTS = 16;
  localparam int MAX_DW    = 128;
  localparam int MAX_KW    = MAX_DW / 8;
  localparam int MAX_IW    = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_PASS
  } arb_state_t;

  typedef struct packed {
    logic [MAX_DW-1:0] data;
    logic [MAX_KW-1:0] keep;
    logic              last;
    logic [MAX_IW-1:0] id;
  } beat_t;

  // Lowest requester above last, else wrap to lowest requester overall.
  function automatic logic [MAX_IW-1:0] rr_next(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_IW-1:0]    last
  );
    logic [MAX_PORTS-1:0] hi;
    logic [MAX_PORTS-1:0] pick;
    hi   = req & ~((MAX_PORTS'(2) << last) - MAX_PORTS'(1));
    pick = (|hi) ? hi : req;
    rr_next = '0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (pick[i]) rr_next = MAX_IW'(i);
    end
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register buffer; outputs come straight from the head entry.
// Ready is "spare entry free", so it never depends on m_ready.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] head;
  logic [W-1:0] spare;
  logic         head_v;
  logic         spare_v;
  logic         push;

  assign s_ready = !spare_v;
  assign push    = s_valid && s_ready;
  assign m_data  = head;
  assign m_valid = head_v;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head    <= '0;
      spare   <= '0;
      head_v  <= 1'b0;
      spare_v <= 1'b0;
    end else if (head_v && m_ready) begin
      if (spare_v) begin
        head    <= spare;
        spare_v <= push;
        if (push) spare <= s_data;
      end else begin
        head_v <= push;
        if (push) head <= s_data;
      end
    end else if (push) begin
      if (!head_v) begin
        head   <= s_data;
        head_v <= 1'b1;
      end else begin
        spare   <= s_data;
        spare_v <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpe_pcap_arbiter.sv
// Packet-level round-robin arbiter feeding the shared PCAP writer.
// A grant is held from first beat to tlast; one bubble per packet.
module dpe_pcap_arbiter
  import dpe_pcap_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32,
  parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [KEEP_WIDTH-1:0]           m_tkeep,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic [ID_WIDTH-1:0]             m_tid,
  input  logic                            m_tready,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count,
  output logic                            busy
);

  arb_state_t            state;
  logic [MAX_IW-1:0]     grant;
  logic [MAX_IW-1:0]     last_grant;
  logic [CNT_WIDTH-1:0]  cnt [NUM_PORTS];
  logic [MAX_PORTS-1:0]  req;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  buf_ready;
  logic                  acc;
  beat_t                 in_beat;
  beat_t                 out_beat;
  logic                  unused_bits;

  always_comb begin
    req       = '0;
    req[NUM_PORTS-1:0] = s_tvalid;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    s_tready  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant == MAX_IW'(p)) begin
        sel_valid   = s_tvalid[p];
        sel_last    = s_tlast[p];
        sel_data    = s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_keep    = s_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
        s_tready[p] = (state == ARB_PASS) && buf_ready;
      end
    end
  end

  assign acc = (state == ARB_PASS) && sel_valid && buf_ready;

  always_comb begin
    in_beat = '0;
    in_beat.data[DATA_WIDTH-1:0] = sel_data;
    in_beat.keep[KEEP_WIDTH-1:0] = sel_keep;
    in_beat.last = sel_last;
    in_beat.id   = grant;
  end

  axis_skid_buf #(
    .W($bits(beat_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (in_beat),
    .s_valid (acc),
    .s_ready (buf_ready),
    .m_data  (out_beat),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= MAX_IW'(NUM_PORTS - 1);
      for (int p = 0; p < NUM_PORTS; p++) cnt[p] <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (|s_tvalid) begin
            grant <= rr_next(req, last_grant);
            state <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (acc && sel_last) begin
            last_grant <= grant;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (acc && sel_last && grant == MAX_IW'(p)) cnt[p] <= cnt[p] + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    assign pkt_count[p*CNT_WIDTH +: CNT_WIDTH] = cnt[p];
  end

  if (NUM_PORTS == 1) begin : g_tid1
    assign m_tid = '0;
  end else begin : g_tidn
    assign m_tid = out_beat.id[ID_WIDTH-1:0];
  end

  assign m_tdata = out_beat.data[DATA_WIDTH-1:0];
  assign m_tkeep = out_beat.keep[KEEP_WIDTH-1:0];
  assign m_tlast = out_beat.last;
  assign busy    = (state == ARB_PASS) || m_tvalid;

  // Padding bits of the shared beat type beyond this instance's widths.
  assign unused_bits = ^{out_beat.data >> DATA_WIDTH,
                         out_beat.keep >> KEEP_WIDTH,
                         out_beat.id >> ID_WIDTH};

endmodule

// File: tb/tb_dpe_pcap_arbiter.sv
// Directed + randomized bench for dpe_pcap_arbiter with a packet scoreboard.
module tb_dpe_pcap_arbiter;

  localparam int NP = 4;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int CW = 32;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } sbeat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            tid;
  } obeat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP*KW-1:0] s_tkeep = '0;
  logic [NP-1:0]    s_tvalid = '0;
  logic [NP-1:0]    s_tlast = '0;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic             m_tready = 1'b1;
  logic [NP*CW-1:0] pkt_count;
  logic             busy;

  logic [NP*DW-1:0] s4_tdata = '0;
  logic [NP*KW-1:0] s4_tkeep = '0;
  logic [NP-1:0]    s4_tvalid = '0;
  logic [NP-1:0]    s4_tlast = '1;
  logic [NP-1:0]    s4_tready;
  logic [DW-1:0]    m4_tdata;
  logic [KW-1:0]    m4_tkeep;
  logic             m4_tvalid;
  logic             m4_tlast;
  logic [IW-1:0]    m4_tid;
  logic             m4_tready = 1'b1;
  logic [NP*4-1:0]  pkt_count4;
  logic             busy4;

  dpe_pcap_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tid(m_tid), .m_tready(m_tready),
    .pkt_count(pkt_count), .busy(busy)
  );

  dpe_pcap_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .CNT_WIDTH(4)
  ) dut4 (
    .clk(clk), .rst(rst),
    .s_tdata(s4_tdata), .s_tkeep(s4_tkeep), .s_tvalid(s4_tvalid),
    .s_tlast(s4_tlast), .s_tready(s4_tready),
    .m_tdata(m4_tdata), .m_tkeep(m4_tkeep), .m_tvalid(m4_tvalid),
    .m_tlast(m4_tlast), .m_tid(m4_tid), .m_tready(m4_tready),
    .pkt_count(pkt_count4), .busy(busy4)
  );

  sbeat_t srcq [NP][$];
  sbeat_t expq [NP][$];
  obeat_t outq [$];
  int     ord [$];
  int     exp_ord [$];
  int     exp_cnt [NP];
  int     rdy_cnt [NP];
  int     acc_cnt [NP];
  int     pat [4] = '{1, 0, 0, 1};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int occ = 0;
  int mode = 0;
  int pat_base = 0;
  int first_rdy = -1;
  int first_mv = -1;
  int gaps = 0;
  int pend_idle = 0;
  bit seen_v = 0;
  bit saw_full = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;
  logic [IW-1:0] prev_tid;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(int p, int len, int gap_at, int gap_len);
    sbeat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.keep = (i == len - 1) ? (KW'($urandom) | KW'(1)) : '1;
      b.last = (i == len - 1);
      b.gap  = (i == gap_at) ? gap_len : 0;
      srcq[p].push_back(b);
      expq[p].push_back(b);
    end
    exp_cnt[p]++;
  endtask

  task automatic tick();
    logic [NP-1:0] hs;
    obeat_t o;
    hs = '0;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
      s_tdata[p*DW +: DW] = '0;
      s_tkeep[p*KW +: KW] = '0;
      if (srcq[p].size() > 0) begin
        if (srcq[p][0].gap > 0) begin
          srcq[p][0].gap = srcq[p][0].gap - 1;
        end else begin
          s_tvalid[p] = 1'b1;
          s_tlast[p]  = srcq[p][0].last;
          s_tdata[p*DW +: DW] = srcq[p][0].data;
          s_tkeep[p*KW +: KW] = srcq[p][0].keep;
        end
      end
    end
    if (mode == 1) m_tready = (pat[(cyc - pat_base) % 4] != 0);
    else if (mode == 2) m_tready = ($urandom_range(0, 3) != 0);
    else m_tready = 1'b1;
    @(negedge clk);
    if (rst) begin
      chk("ready_onehot", DW'($countones(s_tready) <= 1), DW'(1));
      if (occ >= 2) begin
        saw_full = 1;
        chk("ready_when_full", DW'(s_tready), DW'(0));
      end
      if (prev_stall) begin
        chk("stall_data", m_tdata, prev_data);
        chk("stall_ctl", DW'({m_tvalid, m_tkeep, m_tlast, m_tid}),
            DW'({1'b1, prev_keep, prev_last, prev_tid}));
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_keep  = m_tkeep;
      prev_last  = m_tlast;
      prev_tid   = m_tid;
      for (int p = 0; p < NP; p++) begin
        if (s_tready[p]) begin
          rdy_cnt[p]++;
          if (first_rdy < 0) first_rdy = cyc;
        end
        if (s_tvalid[p] && s_tready[p]) begin
          hs[p] = 1'b1;
          occ++;
          acc_cnt[p]++;
        end
      end
      if (m_tvalid) begin
        if (first_mv < 0) first_mv = cyc;
        if (seen_v) gaps += pend_idle;
        pend_idle = 0;
        seen_v = 1;
        if (m_tready) begin
          o.data = m_tdata;
          o.keep = m_tkeep;
          o.last = m_tlast;
          o.tid  = int'(m_tid);
          outq.push_back(o);
          occ--;
        end
      end else if (seen_v) begin
        pend_idle++;
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) void'(srcq[p].pop_front());
    end
  endtask

  function automatic bit pending();
    bit any;
    any = (occ != 0) || m_tvalid;
    for (int p = 0; p < NP; p++) if (srcq[p].size() > 0) any = 1;
    return any;
  endfunction

  task automatic drain(int bound);
    int k;
    k = 0;
    while (pending() && k < bound) begin
      tick();
      k++;
    end
    chk("drain_in_time", DW'(k < bound), DW'(1));
    tick();
    chk("busy_after_drain", DW'(busy), DW'(0));
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      srcq[p].delete();
      expq[p].delete();
      exp_cnt[p] = 0;
      rdy_cnt[p] = 0;
      acc_cnt[p] = 0;
    end
    outq.delete();
    ord.delete();
    occ = 0;
    prev_stall = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_model();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Expected grant sequence: scan upward from last+1, modulo NP.
  task automatic rr_seq(int mask, int last);
    for (int k = 1; k <= NP; k++) begin
      if (mask[(last + k) % NP]) exp_ord.push_back((last + k) % NP);
    end
  endtask

  task automatic check_out();
    obeat_t o;
    sbeat_t e;
    int t;
    while (outq.size() > 0) begin
      t = outq[0].tid;
      ord.push_back(t);
      forever begin
        o = outq.pop_front();
        chk("pkt_tid_const", DW'(o.tid), DW'(t));
        chk("beat_expected", DW'(expq[t].size() > 0), DW'(1));
        if (expq[t].size() == 0) break;
        e = expq[t].pop_front();
        chk("beat_data", o.data, e.data);
        chk("beat_keep", DW'(o.keep), DW'(e.keep));
        chk("beat_last", DW'(o.last), DW'(e.last));
        if (o.last || outq.size() == 0) break;
      end
    end
    for (int p = 0; p < NP; p++) chk("beats_missing", DW'(expq[p].size()), DW'(0));
  endtask

  task automatic check_ord();
    chk("order_len", DW'(ord.size()), DW'(exp_ord.size()));
    for (int i = 0; i < ord.size() && i < exp_ord.size(); i++)
      chk("grant_order", DW'(ord[i]), DW'(exp_ord[i]));
  endtask

  task automatic check_counts();
    for (int p = 0; p < NP; p++)
      chk("pkt_count", DW'(pkt_count[p*CW +: CW]), DW'(exp_cnt[p]));
  endtask

  initial begin
    int c0;
    int k;
    int acc4;
    clear_model();
    repeat (3) tick();
    chk("rst_m_tvalid", DW'(m_tvalid), DW'(0));
    chk("rst_m_tdata", m_tdata, DW'(0));
    chk("rst_m_ctl", DW'({m_tkeep, m_tlast, m_tid}), DW'(0));
    chk("rst_s_tready", DW'(s_tready), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_pkt_count", DW'(pkt_count), DW'(0));
    rst = 1'b1;

    // Port 2 alone, 3 beats
    c0 = cyc + 1;
    first_rdy = -1;
    first_mv = -1;
    add_pkt(2, 3, -1, 0);
    drain(100);
    chk("p2_first_ready", DW'(first_rdy), DW'(c0 + 1));
    chk("p2_ready_cycles", DW'(rdy_cnt[2]), DW'(3));
    chk("p2_latency", DW'(first_mv), DW'(c0 + 2));
    exp_ord.delete();
    rr_seq(4'b0100, 3);
    check_out();
    check_ord();
    check_counts();

    // All ports offer two 2-beat packets each
    do_reset();
    seen_v = 0;
    gaps = 0;
    pend_idle = 0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, 2, -1, 0);
    drain(200);
    exp_ord.delete();
    rr_seq(4'hF, 3);
    rr_seq(4'hF, 3);
    check_out();
    check_ord();
    chk("idle_gaps", DW'(gaps), DW'(7));
    check_counts();

    // Stalled sink during a 5-beat packet from port 1
    ord.delete();
    mode = 1;
    pat_base = cyc + 1;
    saw_full = 0;
    add_pkt(1, 5, -1, 0);
    drain(200);
    mode = 0;
    check_out();
    chk("saw_buffer_full", DW'(saw_full), DW'(1));
    check_counts();

    // Port 0 holes mid-packet while port 3 waits
    ord.delete();
    add_pkt(0, 4, 2, 3);
    tick();
    add_pkt(3, 2, -1, 0);
    drain(200);
    exp_ord.delete();
    exp_ord.push_back(0);
    exp_ord.push_back(3);
    check_out();
    check_ord();
    check_counts();

    // Randomized traffic with random sink backpressure
    ord.delete();
    mode = 2;
    for (int n = 0; n < 12; n++) begin
      int p;
      int len;
      p = $urandom_range(0, NP - 1);
      len = $urandom_range(1, 4);
      add_pkt(p, len, $urandom_range(0, len - 1), $urandom_range(0, 2));
    end
    drain(4000);
    mode = 0;
    check_out();
    check_counts();

    // Reset on beat 2 of a 4-beat packet
    for (int p = 0; p < NP; p++) acc_cnt[p] = 0;
    add_pkt(0, 4, -1, 0);
    k = 0;
    while (acc_cnt[0] < 2 && k < 20) begin
      tick();
      k++;
    end
    chk("mid_pkt_beat2", DW'(acc_cnt[0]), DW'(2));
    rst = 1'b0;
    tick();
    chk("midrst_m_tvalid", DW'(m_tvalid), DW'(0));
    chk("midrst_s_tready", DW'(s_tready), DW'(0));
    chk("midrst_pkt_count", DW'(pkt_count), DW'(0));
    clear_model();
    rst = 1'b1;
    add_pkt(1, 2, -1, 0);
    add_pkt(0, 2, -1, 0);
    drain(200);
    exp_ord.delete();
    rr_seq(4'b0011, 3);
    check_out();
    check_ord();
    check_counts();

    // 4-bit counter wrap on the second instance
    acc4 = 0;
    k = 0;
    s4_tvalid = 4'b0001;
    while (acc4 < 17 && k < 200) begin
      @(negedge clk);
      if (s4_tvalid[0] && s4_tready[0]) acc4++;
      @(posedge clk);
      #1;
      if (acc4 == 17) s4_tvalid = '0;
      k++;
    end
    chk("wrap_pkts_sent", DW'(acc4), DW'(17));
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_count0", DW'(pkt_count4[3:0]), DW'(17 % 16));
    chk("wrap_count_other", DW'(pkt_count4[15:4]), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
